dcache_mem_responder: RTL and testbench

- Memory-side responder for the data cache's memory/L2 port: serves the cache's word-addressed read and write requests from an internal word RAM.
- Adds a fixed, parameterised access latency and returns a one-cycle acknowledge, so the cache's miss/refill FSM can be exercised against realistic timing.
- Sits between the data cache and the top-level data memory. Replaces a zero-latency combinational memory model.

---
 rtl/dcache_mem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_dcache_mem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder
// ---------------------------------------------------------------------------
// Memory-side responder for the data cache's memory/L2 port. Serves the
// cache's word-addressed read and write requests from an internal word RAM,
// adding a fixed access latency and returning a one-cycle acknowledge. It
// replaces a zero-latency combinational memory model so that the cache's
// miss/refill FSM sees realistic timing.
//
// Ports:
//   i_clock      clock; all state updates on the rising edge
//   i_reset      synchronous, active-high reset (aborts any transaction)
//   i_mem_addr   word address from the cache
//   i_mem_we     write request
//   i_mem_re     read request (a write wins when both are high)
//   i_mem_wdata  write data
//   o_mem_rdata  registered read data, valid from the read's ack cycle and
//                held until the next read's ack
//   o_mem_ack    one-cycle pulse: request complete
//   o_mem_busy   request in progress; new requests are not accepted
//   o_mem_error  address fault, only ever high together with o_mem_ack
//   o_dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 ACK)
//
// Handshake: in IDLE a request is accepted on any rising edge where
// i_mem_re or i_mem_we is high; address, data and operation are captured
// then and later input changes are ignored. o_mem_ack rises LATENCY cycles
// after the acceptance edge; the requester keeps re/we asserted until the
// ack cycle and drops them there unless a new request follows. The next
// request can be accepted one cycle after the ack.
//
// Configuration macro: DMEM_RANGE_CHECK_EN
//   undefined (default): the RAM index is the address modulo DEPTH (wraps),
//                        o_mem_error is always 0.
//   defined:             addresses >= DEPTH fault; writes are suppressed,
//                        reads return 0, and o_mem_error is raised with ack.
// ---------------------------------------------------------------------------
module dcache_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic                  i_mem_we,
  input  logic                  i_mem_re,
  input  logic [DATA_WIDTH-1:0] i_mem_wdata,
  output logic [DATA_WIDTH-1:0] o_mem_rdata,
  output logic                  o_mem_ack,
  output logic                  o_mem_busy,
  output logic                  o_mem_error,
  output logic [1:0]            o_dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      lat_idx;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_we;
  logic                  lat_oor;

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  // Request decode on the live inputs (only meaningful in IDLE).
  logic             in_req;
  logic [IDX_W-1:0] in_idx;
  logic             addr_hi;
  logic             in_oor;
  logic             accept;

  assign in_req = i_mem_we | i_mem_re;
  assign in_idx = i_mem_addr[IDX_W-1:0];
  assign accept = (state == ST_IDLE) && in_req;

  // Any address bit above the index field means the address is >= DEPTH.
  generate
    if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
      assign addr_hi = |i_mem_addr[ADDR_WIDTH-1:IDX_W];
    end else begin : g_no_addr_hi
      assign addr_hi = 1'b0;
    end
  endgenerate

  // Without range checking the high bits are simply dropped (wrap-around).
  assign in_oor = RANGE_CHECK && addr_hi;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (in_req) begin
          state_nxt = (LATENCY > 1) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        // Counter was loaded with LATENCY-1 at acceptance; reaching 1 here
        // makes the ack land exactly LATENCY cycles after acceptance.
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  // Ack is masked by reset so a transaction aborted in its ack cycle never
  // reports completion.
  always_comb begin
    o_mem_busy  = (state != ST_IDLE);
    o_mem_ack   = (state == ST_ACK) && !i_reset;
    o_mem_error = o_mem_ack && lat_oor;
    o_dbg_state = state;
  end

  // -------------------------------------------------------------------------
  // Request capture and latency counter
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt       <= '0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_oor   <= 1'b0;
    end else if (accept) begin
      cnt       <= CNT_W'(LATENCY - 1);
      lat_idx   <= in_idx;
      lat_wdata <= i_mem_wdata;
      lat_we    <= i_mem_we;
      lat_oor   <= in_oor;
    end else if (state == ST_WAIT) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Read data register
  // -------------------------------------------------------------------------
  // The read is performed on the edge that enters ACK so the data is valid
  // during the ack cycle. With LATENCY == 1 that edge is the acceptance edge
  // itself, so the live inputs are used instead of the captured ones.
  logic             rd_from_in;
  logic             rd_op;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_oor;
  logic             rd_load;

  always_comb begin
    rd_from_in = (state == ST_IDLE);
    rd_op      = rd_from_in ? (i_mem_re && !i_mem_we) : !lat_we;
    rd_idx     = rd_from_in ? in_idx : lat_idx;
    rd_oor     = rd_from_in ? in_oor : lat_oor;
    rd_load    = (state_nxt == ST_ACK) && rd_op;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_mem_rdata <= '0;
    end else if (rd_load) begin
      o_mem_rdata <= rd_oor ? '0 : ram[rd_idx];
    end
  end

  // -------------------------------------------------------------------------
  // Word RAM (contents survive reset)
  // -------------------------------------------------------------------------
  // The write commits at the end of the ack cycle, before any later request
  // can be accepted, so a following read always sees it.
  always_ff @(posedge i_clock) begin
    if (!i_reset && (state == ST_ACK) && lat_we && !lat_oor) begin
      ram[lat_idx] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb_dcache_mem_responder
// ---------------------------------------------------------------------------
// Bench for dcache_mem_responder (DEPTH=1024, LATENCY=3). A driver issues
// one request at a time and pushes the expected completion (ack cycle,
// read data, error flag) computed from a plain array model of the memory.
// A monitor on the falling edge checks busy/ack/error/rdata every cycle
// against the head of the queue. Honours DMEM_RANGE_CHECK_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_dcache_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 3;
  localparam int POOL  = 64;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          mem_busy;
  logic          mem_error;
  logic [1:0]    dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dcache_mem_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_mem_addr  (mem_addr),
    .i_mem_we    (mem_we),
    .i_mem_re    (mem_re),
    .i_mem_wdata (mem_wdata),
    .o_mem_rdata (mem_rdata),
    .o_mem_ack   (mem_ack),
    .o_mem_busy  (mem_busy),
    .o_mem_error (mem_error),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    int            acc;    // cycle in which the request was presented
    logic [DW-1:0] rdata;  // o_mem_rdata expected from the ack on
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] drv_rd;
  logic [DW-1:0] mon_rdata;
  int            cyc;
  int            n_checks;
  int            n_fail;
  bit            mon_en;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  bit   due;
  logic busy_exp;
  exp_t head;

  always @(negedge clk) begin
    if (mon_en) begin
      due      = (exp_q.size() > 0) && (cyc == exp_q[0].acc + LAT);
      busy_exp = (exp_q.size() > 0) && (cyc > exp_q[0].acc);
      check("busy", mem_busy, busy_exp);
      check("ack", mem_ack, due);
      if (due) begin
        head      = exp_q.pop_front();
        mon_rdata = head.rdata;
        check("error", mem_error, head.err);
      end else begin
        check("error_no_ack", mem_error, 1'b0);
      end
      check("rdata", mem_rdata, mon_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  // One request: presented in an IDLE cycle, held through WAIT (with
  // address/data scrambled to prove they were captured), dropped in ACK.
  task automatic do_req(input logic we, input logic re,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    exp_t        e;
    int unsigned idx;
    logic        oor;
    @(posedge clk); #1;
    idx = addr % DEPTH;
    oor = RC && (addr >= DEPTH);
    if (we) begin
      if (!oor) mem_m[idx] = wdata;
    end else begin
      drv_rd = oor ? '0 : mem_m[idx];
    end
    e.acc   = cyc;
    e.rdata = drv_rd;
    e.err   = oor;
    exp_q.push_back(e);
    mem_we    = we;
    mem_re    = re;
    mem_addr  = addr;
    mem_wdata = wdata;
    @(posedge clk); #1;
    for (int i = 1; i < LAT; i++) begin
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      @(posedge clk); #1;
    end
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = $urandom;
    mem_wdata = $urandom;
  endtask

  // Write that is aborted by reset in its WAIT cycle: no ack, RAM untouched.
  task automatic reset_abort(input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    @(posedge clk); #1;
    mon_en    = 1'b0;
    mem_we    = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    @(posedge clk); #1;
    check("abort_busy_wait", mem_busy, 1'b1);
    rst    = 1'b1;
    mem_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy_after", mem_busy, 1'b0);
    check("abort_ack_after", mem_ack, 1'b0);
    check("abort_rdata_cleared", mem_rdata, '0);
    for (int i = 0; i < LAT + 1; i++) begin
      @(posedge clk); #1;
      check("abort_no_ack", mem_ack, 1'b0);
      check("abort_idle", mem_busy, 1'b0);
    end
    drv_rd    = '0;
    mon_rdata = '0;
    mon_en    = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int unsigned op;
  logic [AW-1:0] ra;

  initial begin
    rst       = 1'b1;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    drv_rd    = '0;
    mon_rdata = '0;
    mon_en    = 1'b0;
    cyc       = 0;
    n_checks  = 0;
    n_fail    = 0;

    // Reset held two cycles, then idle: all outputs must stay quiet.
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Preload the address pool so every read has a known value.
    for (int i = 0; i < POOL; i++) do_req(1'b1, 1'b0, i, $urandom);
    do_req(1'b1, 1'b0, DEPTH - 1, 32'h0BAD_F00D);

    // Directed cases.
    do_req(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    do_req(1'b0, 1'b1, 32'h10, 32'h0);
    do_req(1'b1, 1'b0, 32'h5, 32'h1234);
    do_req(1'b0, 1'b1, 32'h5, 32'h0);
    do_req(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5);   // write wins, rdata held
    do_req(1'b0, 1'b1, 32'h20, 32'h0);
    do_req(1'b1, 1'b0, 32'h400, 32'h77);         // wraps to 0, or faults
    do_req(1'b0, 1'b1, 32'h0, 32'h0);
    do_req(1'b0, 1'b1, 32'h400, 32'h0);
    do_req(1'b0, 1'b1, DEPTH - 1, 32'h0);
    do_req(1'b1, 1'b0, 32'h30, 32'h0);
    reset_abort(32'h30, 32'hFF);
    do_req(1'b0, 1'b1, 32'h30, 32'h0);

    // Randomised traffic over the pool, sometimes with high address bits.
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 2);
      ra = $urandom_range(0, POOL - 1);
      if ($urandom_range(0, 3) == 0) ra = ra + DEPTH * $urandom_range(1, 5);
      case (op)
        0:       do_req(1'b1, 1'b0, ra, $urandom);
        1:       do_req(1'b0, 1'b1, ra, $urandom);
        default: do_req(1'b1, 1'b1, ra, $urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (LAT + 3) @(posedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the run must always end on its own.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
